// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg
// Shared definitions for the round-robin data-bit multiplexer:
//   state_t : arbiter FSM encoding (IDLE = 0, OFFER = 1)
//   log2    : number of bits needed to hold a value (minimum 1), used to
//             size the select/index width from WIDTH-1.
package mux_rr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Bits needed to represent 'value'; never less than one bit.
  function automatic int log2(input int value);
    int bits;
    bits = 32'sd1;
    for (int i = 32'sd1; i < 32'sd31; i++) begin
      if ((value >>> i) != 32'sd0) begin
        bits = i + 32'sd1;
      end else begin
        bits = bits;
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick
// Purely combinational round-robin winner search.
// Ports:
//   req    in  WIDTH      request vector
//   ptr    in  LOG_WIDTH  first index with priority
//   valid  out 1          at least one request is set
//   index  out LOG_WIDTH  lowest set index >= ptr, else lowest set index
//   onehot out WIDTH      one-hot form of index (zero when valid = 0)
module rr_pick #(
  parameter int WIDTH     = 64,
  parameter int LOG_WIDTH = 6
) (
  input  logic [WIDTH-1:0]     req,
  input  logic [LOG_WIDTH-1:0] ptr,
  output logic                 valid,
  output logic [LOG_WIDTH-1:0] index,
  output logic [WIDTH-1:0]     onehot
);

  localparam logic [WIDTH-1:0] ONE_HOT0 = WIDTH'(32'd1);

  logic                 hi_found_s;
  logic                 lo_found_s;
  logic [LOG_WIDTH-1:0] hi_index_s;
  logic [LOG_WIDTH-1:0] lo_index_s;

  // Upward scan: remember the first set bit at/above ptr and the first set bit overall.
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_index_s = '0;
    lo_index_s = '0;
    for (int i = 32'sd0; i < WIDTH; i++) begin
      hi_index_s = (req[i] && !hi_found_s && (i >= int'(ptr))) ? LOG_WIDTH'(i) : hi_index_s;
      hi_found_s = hi_found_s | (req[i] && (i >= int'(ptr)));
      lo_index_s = (req[i] && !lo_found_s) ? LOG_WIDTH'(i) : lo_index_s;
      lo_found_s = lo_found_s | req[i];
    end
  end

  // Prefer the candidate at/above ptr; fall back to the wrapped-around one.
  always_comb begin
    valid  = lo_found_s;
    index  = hi_found_s ? hi_index_s : lo_index_s;
    onehot = lo_found_s ? (ONE_HOT0 << index) : '0;
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
// Round-robin arbiter that forwards the winning requester's data bit to a
// single ready/valid sink. One transfer is committed at a time; back-to-back
// transfers re-arbitrate on the completing edge without a bubble.
// Ports:
//   clk        in  1          clock, rising edge
//   rst        in  1          asynchronous active-high reset
//   req        in  WIDTH      level requests, held until acked
//   data       in  WIDTH      per-requester data bit
//   out_ready  in  1          sink accepts the current transfer
//   lock       in  1          (only with MUX_RR_ARBITER_LOCK_EN) keep the
//                             current requester if it still requests
//   out_valid  out 1          a committed transfer is offered
//   out_data   out 1          registered data bit of the served requester
//   out_sel    out LOG_WIDTH  index of the served requester
//   grant      out WIDTH      one-hot of the served requester, 0 when idle
//   ack        out WIDTH      one-cycle pulse when the transfer completes
// Optional feature macro: MUX_RR_ARBITER_LOCK_EN
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int LOG_WIDTH = log2(WIDTH - 32'sd1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     req,
  input  logic [WIDTH-1:0]     data,
  input  logic                 out_ready,
`ifdef MUX_RR_ARBITER_LOCK_EN
  input  logic                 lock,
`endif
  output logic                 out_valid,
  output logic                 out_data,
  output logic [LOG_WIDTH-1:0] out_sel,
  output logic [WIDTH-1:0]     grant,
  output logic [WIDTH-1:0]     ack
);

  localparam logic [LOG_WIDTH-1:0] LAST_IDX = LOG_WIDTH'(WIDTH - 32'sd1);
  localparam logic [LOG_WIDTH-1:0] ONE_IDX  = LOG_WIDTH'(32'd1);

  state_t               state_r;
  state_t               state_s;
  logic [LOG_WIDTH-1:0] ptr_r;
  logic [LOG_WIDTH-1:0] ptr_s;
  logic [LOG_WIDTH-1:0] ptr_inc_s;
  logic [LOG_WIDTH-1:0] sel_s;
  logic                 data_s;
  logic [WIDTH-1:0]     grant_s;
  logic [WIDTH-1:0]     pick_req_s;
  logic [LOG_WIDTH-1:0] pick_ptr_s;
  logic                 pick_valid_s;
  logic [LOG_WIDTH-1:0] pick_index_s;
  logic [WIDTH-1:0]     pick_onehot_s;
  logic                 relock_s;

`ifdef MUX_RR_ARBITER_LOCK_EN
  assign relock_s = lock & req[out_sel];
`else
  assign relock_s = 1'b0;
`endif

  // Search inputs: while offering, the served requester is masked out and the
  // search starts just past it, so re-arbitration uses the advanced pointer.
  always_comb begin
    ptr_inc_s  = (out_sel == LAST_IDX) ? '0 : (out_sel + ONE_IDX);
    pick_req_s = (state_r == OFFER) ? (req & ~grant) : req;
    pick_ptr_s = (state_r == OFFER) ? ptr_inc_s : ptr_r;
  end

  rr_pick #(
    .WIDTH     (WIDTH),
    .LOG_WIDTH (LOG_WIDTH)
  ) u_pick (
    .req    (pick_req_s),
    .ptr    (pick_ptr_s),
    .valid  (pick_valid_s),
    .index  (pick_index_s),
    .onehot (pick_onehot_s)
  );

  // Next-state logic; everything holds unless a grant is made or a transfer completes.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    sel_s   = out_sel;
    data_s  = out_data;
    grant_s = grant;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_s = OFFER;
          sel_s   = pick_index_s;
          grant_s = pick_onehot_s;
          data_s  = data[pick_index_s];
        end else begin
          grant_s = '0;
        end
      end
      OFFER: begin
        if (!out_ready) begin
          state_s = OFFER;
        end else if (relock_s) begin
          // Locked re-grant: same requester, fresh data bit, pointer untouched.
          data_s = data[out_sel];
        end else begin
          ptr_s = ptr_inc_s;
          if (pick_valid_s) begin
            sel_s   = pick_index_s;
            grant_s = pick_onehot_s;
            data_s  = data[pick_index_s];
          end else begin
            state_s = IDLE;
            grant_s = '0;
          end
        end
      end
      default: begin
        state_s = IDLE;
        grant_s = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      ptr_r     <= '0;
      out_valid <= 1'b0;
      out_data  <= 1'b0;
      out_sel   <= '0;
      grant     <= '0;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      out_valid <= (state_s == OFFER);
      out_data  <= data_s;
      out_sel   <= sel_s;
      grant     <= grant_s;
    end
  end

  // Completion pulse is combinational so the sink sees it in the accepting cycle.
  assign ack = ((state_r == OFFER) && out_ready) ? grant : '0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter
// Directed, scoreboard-based bench for mux_rr_arbiter. Two instances:
// WIDTH=8 (rotation, backpressure, single requester, reset, lock) and
// WIDTH=5 (non-power-of-2 pointer wrap).
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req8, data8, grant8, ack8;
  logic       ready8, lock8, out_valid8, out_data8;
  logic [2:0] sel8;
  logic [4:0] req5, data5, grant5, ack5;
  logic       ready5, lock5, out_valid5, out_data5;
  logic [2:0] sel5;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    int   sel;
    logic dbit;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mux_rr_arbiter #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .req       (req8),
    .data      (data8),
    .out_ready (ready8),
`ifdef MUX_RR_ARBITER_LOCK_EN
    .lock      (lock8),
`endif
    .out_valid (out_valid8),
    .out_data  (out_data8),
    .out_sel   (sel8),
    .grant     (grant8),
    .ack       (ack8)
  );

  mux_rr_arbiter #(.WIDTH(5)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .req       (req5),
    .data      (data5),
    .out_ready (ready5),
`ifdef MUX_RR_ARBITER_LOCK_EN
    .lock      (lock5),
`endif
    .out_valid (out_valid5),
    .out_data  (out_data5),
    .out_sel   (sel5),
    .grant     (grant5),
    .ack       (ack5)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int sel, input logic dbit);
    exp_t e;
    e.sel  = sel;
    e.dbit = dbit;
    sb.push_back(e);
  endtask

  // Samples now (+1) and on following negedges until n acks are seen; every
  // sampled cycle must carry an ack. Returns in the last ack cycle, before
  // the completing edge. With drop=1 the acked requester releases its req.
  task automatic serve(input bit which, input int n, input bit drop);
    int          got;
    int          waited;
    logic [63:0] a;
    exp_t        e;
    got    = 0;
    waited = 0;
    while (got < n && waited < 4 * n + 4) begin
      #1;
      waited++;
      a = which ? 64'(ack5) : 64'(ack8);
      if (a != 64'd0) begin
        if (sb.size() == 0) begin
          check("sb_underflow", a, 64'd0);
        end else begin
          e = sb.pop_front();
          check("ack",   a, 64'd1 << e.sel);
          check("sel",   which ? 64'(sel5) : 64'(sel8), 64'(e.sel));
          check("data",  which ? 64'(out_data5) : 64'(out_data8), 64'(e.dbit));
          check("valid", which ? 64'(out_valid5) : 64'(out_valid8), 64'd1);
        end
        if (drop) begin
          if (which) req5 = req5 & ~a[4:0];
          else       req8 = req8 & ~a[7:0];
        end
        got++;
      end
      if (got < n) @(negedge clk);
    end
    check("served",    64'(got), 64'(n));
    check("no_bubble", 64'(waited), 64'(n));
  endtask

  initial begin
    logic [7:0] dv;
    rst = 1'b1;
    req8 = '0; data8 = '0; ready8 = 1'b0; lock8 = 1'b0;
    req5 = '0; data5 = '0; ready5 = 1'b0; lock5 = 1'b0;

    // Reset state
    @(negedge clk); #1;
    check("rst_valid", 64'(out_valid8), 64'd0);
    check("rst_sel",   64'(sel8),       64'd0);
    check("rst_data",  64'(out_data8),  64'd0);
    check("rst_grant", 64'(grant8),     64'd0);
    check("rst_ack",   64'(ack8),       64'd0);
    check("rst_valid5", 64'(out_valid5), 64'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("idle_noreq", 64'(out_valid8), 64'd0);

    // Rotation: all requesters held, sink always ready
    dv = 8'hA5;
    req8 = 8'hFF; data8 = dv; ready8 = 1'b1;
    for (int k = 0; k < 9; k++) push(k % 8, dv[k % 8]);
    @(negedge clk);
    serve(1'b0, 9, 1'b0);
    req8 = '0;
    @(negedge clk); #1;
    check("rot_idle",  64'(out_valid8), 64'd0);
    check("rot_grant", 64'(grant8),     64'd0);

    // Backpressure: offer must hold while out_ready=0 despite input changes
    req8 = 8'h04; data8 = 8'h04; ready8 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check("bp_valid", 64'(out_valid8), 64'd1);
      check("bp_sel",   64'(sel8),       64'd2);
      check("bp_data",  64'(out_data8),  64'd1);
      check("bp_grant", 64'(grant8),     64'h04);
      check("bp_ack",   64'(ack8),       64'd0);
      if (k == 1) begin
        data8 = 8'h00;
        req8  = 8'h06;
      end
    end
    push(2, 1'b1);
    push(1, 1'b0);
    ready8 = 1'b1;
    serve(1'b0, 2, 1'b1);
    @(negedge clk); #1;
    check("bp_idle", 64'(out_valid8), 64'd0);

    // Single requester: OFFER / IDLE alternate
    req8 = 8'h08; data8 = 8'hFF; ready8 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      check("single_valid", 64'(out_valid8), (k % 2 == 0) ? 64'd1 : 64'd0);
      check("single_ack",   64'(ack8),       (k % 2 == 0) ? 64'h08 : 64'd0);
    end
    req8 = '0;

    // Reset while offering: immediate clear, no ack, pointer restarts at 0
    req8 = 8'h20; data8 = 8'h21; ready8 = 1'b0;
    @(negedge clk); #1;
    check("pre_rst_valid", 64'(out_valid8), 64'd1);
    check("pre_rst_sel",   64'(sel8),       64'd5);
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid8), 64'd0);
    check("arst_sel",   64'(sel8),       64'd0);
    check("arst_data",  64'(out_data8),  64'd0);
    check("arst_grant", 64'(grant8),     64'd0);
    check("arst_ack",   64'(ack8),       64'd0);
    ready8 = 1'b1;
    #1;
    check("arst_ack_ready", 64'(ack8), 64'd0);
    @(negedge clk);
    rst = 1'b0; req8 = 8'h21; ready8 = 1'b0;
    @(negedge clk); #1;
    check("post_rst_valid", 64'(out_valid8), 64'd1);
    check("post_rst_sel",   64'(sel8),       64'd0);
    check("post_rst_data",  64'(out_data8),  64'd1);
    push(0, 1'b1);
    push(5, 1'b1);
    ready8 = 1'b1;
    serve(1'b0, 2, 1'b1);
    @(negedge clk); #1;
    check("post_rst_idle", 64'(out_valid8), 64'd0);

    // Non-power-of-2 wrap on WIDTH=5: serve 3 (ptr -> 4), then 4 and 0
    req5 = 5'h08; data5 = 5'h11; ready5 = 1'b1;
    push(3, 1'b0);
    @(negedge clk);
    serve(1'b1, 1, 1'b1);
    @(negedge clk); #1;
    check("w5_idle", 64'(out_valid5), 64'd0);
    req5 = 5'h11;
    push(4, 1'b1);
    push(0, 1'b1);
    @(negedge clk);
    serve(1'b1, 2, 1'b1);
    @(negedge clk); #1;
    check("w5_idle2", 64'(out_valid5), 64'd0);

`ifdef MUX_RR_ARBITER_LOCK_EN
    // Lock: requester 1 keeps the grant while lock=1, then 2 follows
    req8 = 8'h06; data8 = 8'h06; lock8 = 1'b1; ready8 = 1'b1;
    for (int k = 0; k < 3; k++) push(1, 1'b1);
    @(negedge clk);
    serve(1'b0, 3, 1'b0);
    lock8 = 1'b0;
    push(2, 1'b1);
    @(negedge clk);
    serve(1'b0, 1, 1'b0);
    req8 = '0;
    @(negedge clk); #1;
    check("lock_idle", 64'(out_valid8), 64'd0);
`endif

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
